match_event_stamper: RTL
========================

MATCH_EVENT_STAMPER -- requirements
Module: match_event_stamper

Interface
REQ-001 Parameter DEPTH, 4, timestamp FIFO entries; power of two, >= 2.
REQ-002 Parameter TS_W, 16, timestamp width in bits.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 match_i  input  1  asynchronous combined-event level from the upstream OR/AND event stage.
REQ-006 clear_i  input  1  synchronous flush of FIFO, overflow flag and drop count.
REQ-007 ts_o  output  TS_W  timestamp at the FIFO head.
REQ-008 out_valid_o  output  1  FIFO head holds a valid timestamp.
REQ-009 out_ready_i  input  1  consumer accepts the head this cycle.
REQ-010 level_o  output  1  synchronized match level.
REQ-011 overflow_o  output  1  sticky: at least one event dropped since reset/clear.
REQ-012 drop_cnt_o  output  8  dropped-event count, saturating.

Function
REQ-013 match_i SHALL pass through a 2-flop synchronizer; level_o SHALL be the second flop.
REQ-014 A rising edge SHALL be detected when level_o=1 and its previous-cycle value was 0; exactly one push per edge, none for held high or falling.
REQ-015 Free-running counter ts_q SHALL increment every cycle, wrapping 2^TS_W-1 -> 0.
REQ-016 On detection, ts_q of that cycle SHALL be written to the FIFO tail.
REQ-017 Latency: if match_i is first sampled 1 at edge N, out_valid_o (FIFO empty before) SHALL be 1 after edge N+3, ts_o = ts_q value during cycle between N+2 and N+3.
REQ-018 out_valid_o SHALL equal FIFO not-empty; pop occurs iff out_valid_o & out_ready_i; ts_o SHALL hold stable while out_valid_o=1 and no pop.
REQ-019 Push and pop in the same cycle SHALL both succeed, including when full (occupancy unchanged) and when empty-with-push (no pop, valid next cycle).
REQ-020 Push when full without pop SHALL drop the event: FIFO unchanged, overflow_o set, drop_cnt_o += 1 saturating at 255.
REQ-021 Read/write pointers SHALL be log2(DEPTH)+1 bits; full/empty from pointer MSB compare; wrap without reordering.
REQ-022 clear_i=1 SHALL empty FIFO, clear overflow_o and drop_cnt_o next cycle; a detection in the clear cycle SHALL be discarded; synchronizer, edge history and ts_q unaffected.
REQ-023 clear_i takes priority over push and pop in the same cycle.

Reset
REQ-024 rst_n low SHALL immediately force: synchronizer flops 0, edge history 0, ts_q 0, pointers 0, out_valid_o 0, overflow_o 0, drop_cnt_o 0, level_o 0.
REQ-025 ts_o is don't-care while out_valid_o=0; FIFO storage SHALL not be reset.
REQ-026 Reset mid-operation SHALL discard all queued events; match_i held high across reset release SHALL produce one event once synchronized (history reset to 0).

Structure
REQ-027 Package match_event_pkg SHALL hold TS_W default, DEPTH default, drop counter width 8 and the ts_t typedef.
REQ-028 One sub-module, stamp_fifo (parameterized DEPTH/width, push/pop/clear, full/empty), SHALL hold the storage and pointers; synchronizer, edge detect, ts_q and drop logic stay in the top.

Verification
REQ-029 Reset release, match_i pulse high 3 cycles at ts 10 -> one entry, out_valid_o after 3 edges, ts_o = 12, level_o high 3 cycles.
REQ-030 out_ready_i=0, 6 separated pulses, DEPTH=4 -> 4 entries held in order, overflow_o=1, drop_cnt_o=2; then ready=1 drains 4 in order, valid drops.
REQ-031 FIFO full, pulse coincident with pop -> occupancy stays 4, no drop, new ts at tail.
REQ-032 ts_q preloaded near 0xFFFF via run length, pulses at 0xFFFE and 0x0001 -> ts_o 0xFFFE then 0x0001, order kept.
REQ-033 300 drops with ready=0 -> drop_cnt_o=255; clear_i one cycle -> drop_cnt_o=0, overflow_o=0, out_valid_o=0; ts_q not reset.
REQ-034 rst_n asserted with 3 queued entries and match_i high -> outputs zero asynchronously; after release exactly one new event, 3 cycles later.

Source files
------------

// File: rtl/match_event_pkg.sv
// Shared widths and types for the match event stamper.
package match_event_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 4;
    localparam int DROP_W    = 8;

    typedef logic [TS_W_DEF-1:0] ts_t;
    typedef logic [DROP_W-1:0]   drop_cnt_t;

endpackage

// File: rtl/stamp_fifo.sv
// Timestamp FIFO. Pointers carry one extra wrap bit so full and empty
// are told apart without a separate occupancy counter. Storage is not reset.
module stamp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // still lands when it coincides with a pop. Clear overrides both.
    assign do_pop  = pop & ~empty & ~clear;
    assign do_push = push & ~clear & (~full | do_pop);

    assign dout = mem[rd_ptr[AW-1:0]];

    // Pointer update; clear flushes by collapsing both pointers to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write at the tail.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/match_event_stamper.sv
// Synchronizes the combined match level, detects rising edges and queues
// the free-running timestamp of each edge. Events arriving while the queue
// is full are counted as drops.
module match_event_stamper
    import match_event_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            match_i,
    input  logic            clear_i,
    output logic [TS_W-1:0] ts_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            level_o,
    output logic            overflow_o,
    output drop_cnt_t       drop_cnt_o
);

    logic            sync1_q;
    logic            sync2_q;
    logic            hist_q;
    logic            det_q;
    logic [TS_W-1:0] ts_q;
    logic            rise;
    logic            push;
    logic            pop;
    logic            drop;
    logic            fifo_full;
    logic            fifo_empty;

    assign rise = sync2_q & ~hist_q;

    // Two-flop synchronizer, edge history and a registered detect stage.
    // The detect register places the push one cycle after the edge is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            det_q   <= 1'b0;
        end else begin
            sync1_q <= match_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            det_q   <= rise;
        end
    end

    // Free-running timestamp, wraps naturally; clear does not touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + 1'b1;
    end

    assign pop  = out_valid_o & out_ready_i;
    assign push = det_q & ~clear_i;
    assign drop = push & fifo_full & ~pop;

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (clear_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end

    stamp_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_i),
        .push  (push),
        .din   (ts_q),
        .pop   (pop),
        .dout  (ts_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid_o = ~fifo_empty;
    assign level_o     = sync2_q;

endmodule
